// File: rtl/cmul_share_arb.sv
// Round-robin scheduler sharing one complex_mul datapath among NREQ requesters, with tagged results.
// Define CMUL_ARB_STATS_EN to add per-requester 16-bit wrapping grant counters (grant_cnt port).
module cmul_share_arb #(
  parameter int N    = 4,
  parameter int NREQ = 4,
  parameter int LAT  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*(2**N)-1:0]    req_ra,
  input  logic [NREQ*(2**N)-1:0]    req_rb,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      hold,
  output logic                      idle,
  output logic [(2**N)-1:0]         dp_ra,
  output logic [(2**N)-1:0]         dp_rb,
  input  logic [(2**N)-1:0]         dp_real,
  input  logic [(2**N)-1:0]         dp_imag,
  output logic                      rsp_valid,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [(2**N)-1:0]         rsp_real,
  output logic [(2**N)-1:0]         rsp_imag
`ifdef CMUL_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]        grant_cnt
`endif
);

  localparam int W  = 2**N;
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gnt_id;
  logic            gnt_any;
  logic [LAT-1:0]  tag_v;
  logic [IW-1:0]   tag_id [LAT];
  logic            pipe_empty;
  int unsigned     idx;

  // rsp_valid is the last tag stage, so the pipe only counts as empty once it has dropped
  assign pipe_empty = ~|tag_v & ~rsp_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:     if (hold) state_nx = DRAIN;
      DRAIN:   if (!hold) state_nx = RUN;
               else if (pipe_empty) state_nx = HALT;
      HALT:    if (!hold) state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  always_comb begin
    gnt_any   = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    req_ready = '0;
    if (!rst && state == RUN && !hold) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = (32'(ptr) + k) % NREQ;
        if (!gnt_any && req_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_id  = IW'(idx);
        end
      end
    end
    if (gnt_any) req_ready = NREQ'(1) << gnt_id;
    idle = pipe_empty & ~gnt_any;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      dp_ra     <= '0;
      dp_rb     <= '0;
      tag_v     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      for (int unsigned s = 0; s < LAT; s++) tag_id[s] <= '0;
    end else begin
      if (gnt_any) begin
        ptr   <= (gnt_id == IW'(NREQ-1)) ? '0 : gnt_id + IW'(1);
        dp_ra <= req_ra[gnt_id*W +: W];
        dp_rb <= req_rb[gnt_id*W +: W];
      end
      tag_v[0]  <= gnt_any;
      tag_id[0] <= gnt_id;
      for (int unsigned s = 1; s < LAT; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
      rsp_valid <= tag_v[LAT-1];
      rsp_id    <= tag_id[LAT-1];
    end
  end

  assign rsp_real = dp_real;
  assign rsp_imag = dp_imag;

`ifdef CMUL_ARB_STATS_EN
  logic [15:0] cnt [NREQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i]) cnt[i] <= cnt[i] + 16'd1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < NREQ; i++) grant_cnt[i*16 +: 16] = cnt[i];
  end
`endif

endmodule
